// File: rtl/nmi_event_ctrl.sv
// NMI event controller: latches user event edges, raises NMI, pages in the config ROM
// while the handler runs, and tracks acknowledge timeouts.
module nmi_event_ctrl #(
   parameter int          NUM_EVENTS     = 5,
   parameter logic [7:0]  REG_ADDR       = 8'h08,
   parameter logic [15:0] NMI_VECTOR     = 16'h0066,
   parameter logic [15:0] EXIT_ADDR      = 16'h006A,
   parameter int          ASSERT_TIMEOUT = 4096
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            zxuno_addr,
   input  logic                  zxuno_regrd,
   input  logic                  zxuno_regwr,
   input  logic [7:0]            din,
   input  logic [NUM_EVENTS-1:0] userevents,
   input  logic [15:0]           a,
   input  logic                  m1_n,
   input  logic                  mreq_n,
   input  logic                  rd_n,
   output logic [7:0]            dout,
   output logic                  oe_n,
   output logic                  nmiout_n,
   output logic                  page_configrom_active
);

   localparam int CW = $clog2(ASSERT_TIMEOUT) + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_HANDLER, ST_EXITING} state_t;

   state_t                state, state_d;
   logic [NUM_EVENTS-1:0] evt_q, pending, pending_d, active, active_d, rise, w1c;
   logic                  nmi_d, page_d, timeout_flag, tflag_d;
   logic [CW-1:0]         counter, cnt_d;
   logic                  reg_wr, ack, exit_fetch;

   assign rise       = userevents & ~evt_q;
   assign reg_wr     = zxuno_regwr && (zxuno_addr == REG_ADDR);
   assign w1c        = reg_wr ? din[NUM_EVENTS-1:0] : '0;
   assign ack        = !mreq_n && !m1_n && (a == NMI_VECTOR);
   assign exit_fetch = !mreq_n && !m1_n && !rd_n && (a == EXIT_ADDR);
   assign oe_n       = !((zxuno_addr == REG_ADDR) && zxuno_regrd);

   always_comb begin
      dout                 = '0;
      dout[NUM_EVENTS-1:0] = active;
      dout[7]              = timeout_flag;
   end

   always_comb begin
      state_d   = state;
      // New edges always land in pending, so set beats a same-cycle clear
      pending_d = (pending & ~w1c) | rise;
      active_d  = active;
      nmi_d     = nmiout_n;
      page_d    = page_configrom_active;
      tflag_d   = timeout_flag & ~(reg_wr & din[7]);
      cnt_d     = counter;
      case (state)
         ST_IDLE: begin
            if (pending != '0) begin
               active_d  = pending;
               pending_d = rise;
               nmi_d     = 1'b0;
               page_d    = 1'b1;
               cnt_d     = '0;
               state_d   = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            if (ack) begin
               nmi_d   = 1'b1;
               state_d = ST_HANDLER;
            end else if (counter == CW'(ASSERT_TIMEOUT - 1)) begin
               // Unacknowledged NMI: drop the active events and flag it
               nmi_d    = 1'b1;
               page_d   = 1'b0;
               active_d = '0;
               tflag_d  = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               cnt_d = counter + 1'b1;
            end
         end
         ST_HANDLER: begin
            if (exit_fetch) state_d = ST_EXITING;
         end
         ST_EXITING: begin
            if (m1_n) begin
               page_d   = 1'b0;
               active_d = '0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state                 <= ST_IDLE;
         nmiout_n              <= 1'b1;
         page_configrom_active <= 1'b0;
         pending               <= '0;
         active                <= '0;
         timeout_flag          <= 1'b0;
         counter               <= '0;
         evt_q                 <= userevents;
      end else begin
         state                 <= state_d;
         nmiout_n              <= nmi_d;
         page_configrom_active <= page_d;
         pending               <= pending_d;
         active                <= active_d;
         timeout_flag          <= tflag_d;
         counter               <= cnt_d;
         evt_q                 <= userevents;
      end
   end

endmodule

// File: tb/tb_nmi_event_ctrl.sv
// Scoreboard bench for nmi_event_ctrl: each register read probe queues the expected
// {nmiout_n, page, dout}; the monitor checks whenever the DUT drives oe_n low.
module tb_nmi_event_ctrl;

   localparam logic [7:0] REG = 8'h08;

   typedef struct packed {
      logic       nmi;
      logic       page;
      logic [7:0] dout;
      logic [7:0] id;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  zxuno_addr, din, dout;
   logic        zxuno_regrd, zxuno_regwr;
   logic [4:0]  userevents;
   logic [15:0] a;
   logic        m1_n, mreq_n, rd_n;
   logic        oe_n, nmiout_n, page_configrom_active;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   bit   done  = 1'b0;

   nmi_event_ctrl dut (
      .clk(clk), .rst_n(rst_n), .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
      .zxuno_regwr(zxuno_regwr), .din(din), .userevents(userevents), .a(a),
      .m1_n(m1_n), .mreq_n(mreq_n), .rd_n(rd_n), .dout(dout), .oe_n(oe_n),
      .nmiout_n(nmiout_n), .page_configrom_active(page_configrom_active)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic probe(input logic nmi, input logic page, input logic [7:0] d, input logic [7:0] id);
      exp_t e;
      e.nmi = nmi; e.page = page; e.dout = d; e.id = id;
      q.push_back(e);
      zxuno_addr  = REG;
      zxuno_regrd = 1'b1;
      tick();
      zxuno_regrd = 1'b0;
      zxuno_addr  = 8'h00;
   endtask

   task automatic bus(input logic [15:0] addr, input logic m1, input logic mreq, input logic rd);
      a = addr; m1_n = m1; mreq_n = mreq; rd_n = rd;
   endtask

   task automatic ack_fetch();
      bus(16'h0066, 1'b0, 1'b0, 1'b0);
      tick();
      bus(16'h0000, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic exit_seq();
      bus(16'h006A, 1'b0, 1'b0, 1'b0);
      tick();
      bus(16'h0000, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic reg_write(input logic [7:0] v);
      zxuno_addr = REG; din = v; zxuno_regwr = 1'b1;
      tick();
      zxuno_regwr = 1'b0; zxuno_addr = 8'h00; din = 8'h00;
   endtask

   // Monitor: the read strobe is the DUT's output-valid
   always @(negedge clk) begin
      if (!done && !oe_n) begin
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_read: oe_n low with no expectation queued, dout=%h", dout);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (nmiout_n !== e.nmi || page_configrom_active !== e.page || dout !== e.dout) begin
               fails++;
               $display("FAIL probe_%0d: got nmi=%b page=%b dout=%h, want nmi=%b page=%b dout=%h",
                        e.id, nmiout_n, page_configrom_active, dout, e.nmi, e.page, e.dout);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; zxuno_addr = 8'h00; zxuno_regrd = 1'b0; zxuno_regwr = 1'b0;
      din = 8'h00; userevents = 5'b00000;
      bus(16'h0000, 1'b1, 1'b1, 1'b1);
      tick(2);
      probe(1, 0, 8'h00, 1);                 // reset state
      rst_n = 1'b1;
      tick();
      probe(1, 0, 8'h00, 2);

      // Single event: bit2 rises, NMI, acknowledge
      userevents = 5'b00100;
      tick();
      probe(1, 0, 8'h00, 3);                 // edge only reached pending so far
      probe(0, 1, 8'h04, 4);
      ack_fetch();
      probe(1, 1, 8'h04, 5);
      // Exit: fetch at EXIT_ADDR, then one cycle still in EXITING state
      exit_seq();
      probe(1, 1, 8'h04, 6);
      probe(1, 0, 8'h00, 7);

      // Bit1 queued while bit0 is being serviced
      userevents = 5'b00101;
      tick(2);
      probe(0, 1, 8'h01, 8);
      ack_fetch();
      userevents = 5'b00111;
      tick();
      probe(1, 1, 8'h01, 9);
      exit_seq();
      tick();
      probe(1, 0, 8'h00, 10);                // mandatory idle gap
      probe(0, 1, 8'h02, 11);
      ack_fetch();
      exit_seq();
      tick();
      probe(1, 0, 8'h00, 12);
      tick(3);
      probe(1, 0, 8'h00, 13);                // held-high lines give no second NMI

      // W1C in the same cycle as a rise: set wins
      userevents = 5'b01111;
      reg_write(8'h08);
      tick();
      probe(0, 1, 8'h08, 14);
      ack_fetch();
      // W1C that does clear a queued bit
      userevents = 5'b11111;
      tick();
      reg_write(8'h10);
      exit_seq();
      tick();
      probe(1, 0, 8'h00, 15);
      probe(1, 0, 8'h00, 16);

      // Timeout: NMI low for exactly 4096 cycles
      userevents = 5'b11110;
      tick();
      userevents = 5'b11111;
      tick(2);
      probe(0, 1, 8'h01, 17);                // assert cycle 1
      tick(4094);
      probe(0, 1, 8'h01, 18);                // assert cycle 4096, last one
      probe(1, 0, 8'h80, 19);
      reg_write(8'h80);
      probe(1, 0, 8'h00, 20);

      // Reset in the middle of ASSERT
      userevents = 5'b11110;
      tick();
      userevents = 5'b11111;
      tick(2);
      probe(0, 1, 8'h01, 21);
      rst_n = 1'b0;
      tick();
      probe(1, 0, 8'h00, 22);
      rst_n = 1'b1;
      tick(3);
      probe(1, 0, 8'h00, 23);
      userevents = 5'b11110;
      tick();
      userevents = 5'b11111;
      tick(2);
      probe(0, 1, 8'h01, 24);

      tick(2);
      done = 1'b1;
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
